// File: rtl/mem_responder.sv
// Word-addressed RAM responder with a fixed per-access wait count and MemReady/MemError pulses.
// Optional MEM_RESET_CLEAR_EN: reset also zeroes every array word.
module mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  MemReady,
    output logic                  MemError
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    error_q, error_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    req_err;

    assign idx = addr_q[ADDR_WIDTH+1:2];

    // Misaligned, beyond the array, or read/write conflict on the latched request.
    assign req_err = (addr_q[1:0] != 2'b00)
                  || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0)
                  || (rd_q && wr_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = Address;
                    wdata_d = WriteData;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    error_d = req_err;
                    if (!req_err) begin
                        if (rd_q) rdata_d = mem_q[idx];
                        if (wr_q) mem_we = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Reset blocks the commit so an access interrupted in WAIT never lands.
    always_ff @(posedge clk) begin
`ifdef MEM_RESET_CLEAR_EN
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
`else
        if (!reset && mem_we) begin
            mem_q[idx] <= wdata_q;
        end
`endif
    end

    assign ReadData = rdata_q;
    assign MemReady = ready_q;
    assign MemError = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_WIDTH=8, LATENCY=2), checks with immediate assertions.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemError;

    int checks = 0;
    int errors = 0;

    mem_responder #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .LATENCY   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Address  (Address),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .MemReady (MemReady),
        .MemError (MemError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns negedges counted until MemReady (0 on timeout).
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input bit hold,
                          output int lat, output logic err, output logic [31:0] rdat);
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wd;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!hold) begin
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end
            if (MemReady) begin
                lat = i;
                break;
            end
        end
        err  = MemError;
        rdat = ReadData;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        check("ready_pulse_ends", {31'd0, MemReady}, 32'd0);
    endtask

    int          lat;
    logic        err;
    logic [31:0] rdat;
    logic [31:0] exp10;
    logic [31:0] exp20;
    int          seen;
    int          first_pulse;
    int          second_pulse;
    int          pulses;

    initial begin
`ifdef MEM_RESET_CLEAR_EN
        exp10 = 32'h0;
        exp20 = 32'h0;
`else
        exp10 = 32'hDEAD_BEEF;
        exp20 = 32'hAAAA_0000;
`endif
        reset = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        Address = 32'h0;
        WriteData = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_readdata", ReadData, 32'h0);
        check("reset_ready", {31'd0, MemReady}, 32'd0);
        check("reset_error", {31'd0, MemError}, 32'd0);

        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, lat, err, rdat);
        check("wr10_latency", lat, 3);
        check("wr10_error", {31'd0, err}, 32'd0);

        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, lat, err, rdat);
        check("rd10_latency", lat, 3);
        check("rd10_error", {31'd0, err}, 32'd0);
        check("rd10_data", rdat, 32'hDEAD_BEEF);

        access(1'b1, 1'b0, 32'h12, 32'h0, 1'b1, lat, err, rdat);
        check("misaligned_latency", lat, 3);
        check("misaligned_error", {31'd0, err}, 32'd1);
        check("misaligned_data_kept", rdat, 32'hDEAD_BEEF);

        access(1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b1, lat, err, rdat);
        check("wr0_error", {31'd0, err}, 32'd0);
        access(1'b0, 1'b1, 32'h400, 32'h2222_2222, 1'b1, lat, err, rdat);
        check("oor_latency", lat, 3);
        check("oor_error", {31'd0, err}, 32'd1);
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, lat, err, rdat);
        check("rd0_after_oor", rdat, 32'h1111_1111);
        check("rd0_error", {31'd0, err}, 32'd0);

        access(1'b1, 1'b1, 32'h10, 32'h5555_5555, 1'b1, lat, err, rdat);
        check("conflict_error", {31'd0, err}, 32'd1);
        check("conflict_data_kept", rdat, 32'h1111_1111);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, err, rdat);
        check("dropped_req_latency", lat, 3);
        check("rd10_after_conflict", rdat, 32'hDEAD_BEEF);

        access(1'b0, 1'b1, 32'h20, 32'hAAAA_0000, 1'b1, lat, err, rdat);
        check("wr20_error", {31'd0, err}, 32'd0);

        // Write to 0x20 interrupted by reset while in WAIT.
        MemWrite  = 1'b1;
        Address   = 32'h20;
        WriteData = 32'hBBBB_BBBB;
        @(negedge clk);
        reset    = 1'b1;
        MemWrite = 1'b0;
        @(negedge clk);
        check("abort_ready_in_reset", {31'd0, MemReady}, 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (MemReady) seen++;
        end
        check("abort_no_ready", seen, 0);
        check("abort_readdata_reset", ReadData, 32'h0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, lat, err, rdat);
        check("rd20_after_abort", rdat, exp20);

        // MemRead held high: one completion every LATENCY+2 cycles.
        MemRead = 1'b1;
        Address = 32'h10;
        pulses = 0;
        first_pulse = 0;
        second_pulse = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (MemReady) begin
                pulses++;
                if (pulses == 1) first_pulse = i;
                if (pulses == 2) second_pulse = i;
            end
        end
        MemRead = 1'b0;
        check("held_pulse_count", pulses, 2);
        check("held_first_pulse", first_pulse, 3);
        check("held_second_pulse", second_pulse, 7);
        check("held_read_data", ReadData, exp10);
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
